pc_fetch_unit: RTL and testbench

Fetch-stage program-counter unit for the 54-instruction MIPS CPU. It holds the architectural PC and computes the next PC from five sources: sequential, branch, jump, register, and exception/eret. It drives the instruction-memory request with a ready handshake. It consumes branch offsets, jump indices, register targets and CP0 targets from decode/execute. It feeds the fetched PC and PC+4 downstream to the link-address and target-formation logic.

---
 rtl/pc_fetch_unit_if.sv | 44 ++++
 rtl/pc_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Bundle of fetch-stage signals: redirect inputs from
//               decode/execute, the instruction-memory handshake, and the
//               PC values sent downstream.
//               master = fetch unit side, slave = surrounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
    // Pipeline control and redirect sources
    logic        stall;
    logic        redir_valid;
    logic [2:0]  npc_sel;
    logic [15:0] br_off;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] exc_target;
    // Instruction-memory handshake
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    // PC values for downstream logic and alignment status
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        addr_err;
    logic [31:0] bad_vaddr;

    modport master (
        input  stall, redir_valid, npc_sel, br_off, j_index, jr_target,
               exc_target, imem_ready,
        output imem_req, imem_addr, pc, pc_plus4, inst_valid, addr_err,
               bad_vaddr
    );

    modport slave (
        output stall, redir_valid, npc_sel, br_off, j_index, jr_target,
               exc_target, imem_ready,
        input  imem_req, imem_addr, pc, pc_plus4, inst_valid, addr_err,
               bad_vaddr
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Fetch-stage PC register and next-PC selection (sequential,
//               branch, jump, register, exception/eret) with an
//               instruction-memory ready handshake and a one-entry pending
//               redirect latch for redirects that arrive while a fetch is
//               still outstanding.
//               Optional macro PC_ALIGN_CHECK_EN: reject misaligned
//               register/exception targets and report them on
//               addr_err/bad_vaddr. Without it, target bits [1:0] are
//               forced to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_REG    = 3'd3;
    localparam logic [2:0] SEL_EXC    = 3'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_v_q, pend_v_d;
    logic        pend_exc_q, pend_exc_d;
    logic [31:0] bad_vaddr_q, bad_vaddr_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] reg_target;
    logic [31:0] exc_target;
    logic        reg_bad;
    logic        exc_bad;
    logic        cur_exc;
    logic        cur_norm;
    logic [31:0] cur_norm_target;
    logic        complete;
    logic        addr_err;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {{14{bus.br_off[15]}}, bus.br_off, 2'b00};
    assign j_target  = {pc_plus4[31:28], bus.j_index, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign reg_target = bus.jr_target;
    assign exc_target = bus.exc_target;
    assign reg_bad    = |bus.jr_target[1:0];
    assign exc_bad    = |bus.exc_target[1:0];
`else
    // Low target bits are simply dropped, so no target is ever rejected.
    logic unused_low_bits;
    assign unused_low_bits = ^{bus.jr_target[1:0], bus.exc_target[1:0]};
    assign reg_target = {bus.jr_target[31:2], 2'b00};
    assign exc_target = {bus.exc_target[31:2], 2'b00};
    assign reg_bad    = 1'b0;
    assign exc_bad    = 1'b0;
`endif

    // Classify this cycle's redirect: exception vs. ordinary taken target.
    always_comb begin
        cur_exc         = bus.redir_valid && (bus.npc_sel == SEL_EXC) && !exc_bad;
        cur_norm        = 1'b0;
        cur_norm_target = pc_plus4;
        if (bus.redir_valid) begin
            case (bus.npc_sel)
                SEL_BRANCH: begin cur_norm = 1'b1;     cur_norm_target = br_target;  end
                SEL_JUMP:   begin cur_norm = 1'b1;     cur_norm_target = j_target;   end
                SEL_REG:    begin cur_norm = !reg_bad; cur_norm_target = reg_target; end
                default:    ;
            endcase
        end
        addr_err = bus.redir_valid &&
                   (((bus.npc_sel == SEL_REG) && reg_bad) ||
                    ((bus.npc_sel == SEL_EXC) && exc_bad));
    end

    // A fetch completes when its word is in hand and the pipeline accepts it.
    always_comb begin
        complete = ((state_q == S_FETCH) && bus.imem_ready && !bus.stall) ||
                   ((state_q == S_HOLD) && !bus.stall);
    end

    // Next-state, next-PC, pending-latch and bad-address computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        pend_v_d    = pend_v_q;
        pend_exc_d  = pend_exc_q;
        bad_vaddr_d = bad_vaddr_q;

        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: if (bus.imem_ready && bus.stall) state_d = S_HOLD;
            S_HOLD:  if (!bus.stall) state_d = S_FETCH;
            default: state_d = S_RST;
        endcase

        if (complete) begin
            if (cur_exc)       pc_d = exc_target;
            else if (cur_norm) pc_d = cur_norm_target;
            else if (pend_v_q) pc_d = pend_pc_q;
            else               pc_d = pc_plus4;
            pend_v_d   = 1'b0;
            pend_exc_d = 1'b0;
        end else if (cur_exc) begin
            pend_pc_d  = exc_target;
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b1;
        end else if (cur_norm && !(pend_v_q && pend_exc_q)) begin
            // A held exception redirect must not be displaced by ordinary flow.
            pend_pc_d  = cur_norm_target;
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b0;
        end

        if (addr_err) begin
            bad_vaddr_d = (bus.npc_sel == SEL_REG) ? bus.jr_target : bus.exc_target;
        end
    end

    // State and PC registers; reset takes effect asynchronously mid-fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            pc_q        <= RESET_PC;
            pend_pc_q   <= 32'd0;
            pend_v_q    <= 1'b0;
            pend_exc_q  <= 1'b0;
            bad_vaddr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            pend_v_q    <= pend_v_d;
            pend_exc_q  <= pend_exc_d;
            bad_vaddr_q <= bad_vaddr_d;
        end
    end

    assign bus.imem_req   = (state_q == S_FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.inst_valid = complete;
    assign bus.addr_err   = addr_err;
    assign bus.bad_vaddr  = bad_vaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit: directed scenarios
//               followed by random stimulus compared against a behavioural
//               model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = just out of reset, 1 = request outstanding, 2 = word held
    int          m_phase;
    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_pend_exc;
    logic [31:0] m_pend_pc;
    logic [31:0] m_bad;

    task automatic model_reset();
        m_phase    = 0;
        m_pc       = RESET_PC;
        m_pend     = 1'b0;
        m_pend_exc = 1'b0;
        m_pend_pc  = 32'd0;
        m_bad      = 32'd0;
    endtask

    function automatic logic [31:0] target(input logic [2:0] sel);
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        case (sel)
            3'd1:    return seq + 32'(int'($signed(bus.br_off)) * 4);
            3'd2:    return (seq & 32'hF000_0000) | (32'(bus.j_index) << 2);
            3'd3:    return ALIGN_CHK ? bus.jr_target  : (bus.jr_target  & ~32'h3);
            3'd4:    return ALIGN_CHK ? bus.exc_target : (bus.exc_target & ~32'h3);
            default: return seq;
        endcase
    endfunction

    function automatic bit misaligned(input logic [2:0] sel);
        bit raw;
        raw = ((sel == 3'd3) && (bus.jr_target[1:0]  != 2'b00)) ||
              ((sel == 3'd4) && (bus.exc_target[1:0] != 2'b00));
        return ALIGN_CHK && raw;
    endfunction

    // One clock cycle: drive at negedge, check outputs, advance the model.
    task automatic cyc(input bit st, input bit rv, input logic [2:0] sel,
                       input logic [15:0] off, input logic [25:0] ji,
                       input logic [31:0] jr, input logic [31:0] ex, input bit rdy);
        bit          done;
        bit          aerr;
        bit          take_exc;
        bit          take_norm;
        logic [31:0] nxt;
        @(negedge clk);
        bus.stall       = st;
        bus.redir_valid = rv;
        bus.npc_sel     = sel;
        bus.br_off      = off;
        bus.j_index     = ji;
        bus.jr_target   = jr;
        bus.exc_target  = ex;
        bus.imem_ready  = rdy;
        #1;
        done      = ((m_phase == 1) && rdy && !st) || ((m_phase == 2) && !st);
        aerr      = rv && misaligned(sel);
        take_exc  = rv && (sel == 3'd4) && !misaligned(sel);
        take_norm = rv && (sel >= 3'd1) && (sel <= 3'd3) && !misaligned(sel);
        check("pc",         bus.pc,              m_pc);
        check("pc_plus4",   bus.pc_plus4,        m_pc + 32'd4);
        check("imem_addr",  bus.imem_addr,       m_pc);
        check("imem_req",   32'(bus.imem_req),   32'(m_phase == 1));
        check("inst_valid", 32'(bus.inst_valid), 32'(done));
        check("addr_err",   32'(bus.addr_err),   32'(aerr));
        check("bad_vaddr",  bus.bad_vaddr,       m_bad);
        if (take_exc)       nxt = target(sel);
        else if (take_norm) nxt = target(sel);
        else if (m_pend)    nxt = m_pend_pc;
        else                nxt = m_pc + 32'd4;
        if (aerr) m_bad = (sel == 3'd3) ? jr : ex;
        if (done) begin
            m_pc       = nxt;
            m_pend     = 1'b0;
            m_pend_exc = 1'b0;
            m_phase    = 1;
        end else begin
            if (take_exc) begin
                m_pend = 1'b1; m_pend_exc = 1'b1; m_pend_pc = target(sel);
            end else if (take_norm && !(m_pend && m_pend_exc)) begin
                m_pend = 1'b1; m_pend_exc = 1'b0; m_pend_pc = target(sel);
            end
            if (m_phase == 0)                   m_phase = 1;
            else if (m_phase == 1 && rdy && st) m_phase = 2;
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit rdy, input bit st);
        cyc(st, 1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 32'd0, rdy);
    endtask

    // Assert reset between edges, check it acted at once, release before next negedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_pc",        bus.pc,              RESET_PC);
        check("rst_pc_plus4",  bus.pc_plus4,        RESET_PC + 32'd4);
        check("rst_imem_req",  32'(bus.imem_req),   32'd0);
        check("rst_inst_valid",32'(bus.inst_valid & bus.imem_ready & ~bus.stall), 32'd0);
        check("rst_addr_err",  32'(bus.addr_err & ~bus.redir_valid), 32'd0);
        check("rst_bad_vaddr", bus.bad_vaddr,       32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b1;
        bus.stall       = 1'b0;
        bus.redir_valid = 1'b0;
        bus.npc_sel     = 3'd0;
        bus.br_off      = 16'd0;
        bus.j_index     = 26'd0;
        bus.jr_target   = 32'd0;
        bus.exc_target  = 32'd0;
        bus.imem_ready  = 1'b1;
        model_reset();
        do_reset();

        // Sequential fetch from reset at one per cycle
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        #1 check("seq_first", bus.pc, 32'h0040_0004);
        idle(1'b1, 1'b0);
        #1 check("seq_second", bus.pc, 32'h0040_0008);

        // Branch backwards from 0x0040_0010
        for (int i = 0; i < 16 && m_pc != 32'h0040_0010; i++) idle(1'b1, 1'b0);
        cyc(1'b0, 1'b1, 3'd1, 16'hFFFC, 26'd0, 32'd0, 32'd0, 1'b1);
        #1 check("branch", bus.pc, 32'h0040_0004);

        // Jump from 0x0040_0020
        for (int i = 0; i < 16 && m_pc != 32'h0040_0020; i++) idle(1'b1, 1'b0);
        cyc(1'b0, 1'b1, 3'd2, 16'd0, 26'h010_0040, 32'd0, 32'd0, 1'b1);
        #1 check("jump", bus.pc, 32'h0040_0100);

        // Register redirect held in pending while memory is slow
        cyc(1'b0, 1'b1, 3'd3, 16'd0, 26'd0, 32'h0040_1000, 32'd0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        #1 check("pend_reg", bus.pc, 32'h0040_1000);

        // Later branch overwrites pending register redirect (pc+4+0x40)
        cyc(1'b0, 1'b1, 3'd3, 16'd0, 26'd0, 32'h0040_2000, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 3'd1, 16'h0010, 26'd0, 32'd0, 32'd0, 1'b0);
        idle(1'b1, 1'b0);
        #1 check("pend_branch", bus.pc, 32'h0040_1044);

        // Exception redirect wins and is not displaced afterwards
        cyc(1'b0, 1'b1, 3'd3, 16'd0, 26'd0, 32'h0040_3000, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 3'd1, 16'h0020, 26'd0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 3'd4, 16'd0, 26'd0, 32'd0, 32'h0040_0004, 1'b0);
        cyc(1'b0, 1'b1, 3'd3, 16'd0, 26'd0, 32'h0040_5000, 32'd0, 1'b0);
        idle(1'b1, 1'b0);
        #1 check("pend_exc", bus.pc, 32'h0040_0004);

        // Stall across ready: hold, then release advances by 4
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        #1 check("hold_pc", bus.pc, 32'h0040_0004);
        check("hold_req", 32'(bus.imem_req), 32'd0);
        idle(1'b0, 1'b0);
        #1 check("hold_release", bus.pc, 32'h0040_0008);

        // Reset while holding with a pending redirect: redirect is lost
        idle(1'b1, 1'b1);
        cyc(1'b1, 1'b1, 3'd3, 16'd0, 26'd0, 32'h0040_7000, 32'd0, 1'b1);
        do_reset();
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        #1 check("pend_lost", bus.pc, 32'h0040_0004);

        // Misaligned register target
        cyc(1'b0, 1'b1, 3'd3, 16'd0, 26'd0, 32'h0040_0102, 32'd0, 1'b1);
        #1 check("align", bus.pc, ALIGN_CHK ? 32'h0040_0008 : 32'h0040_0100);

        // pc_plus4 wraps silently
        cyc(1'b0, 1'b1, 3'd3, 16'd0, 26'd0, 32'hFFFF_FFFC, 32'd0, 1'b1);
        #1 check("wrap_plus4", bus.pc_plus4, 32'd0);
        idle(1'b1, 1'b0);
        #1 check("wrap_pc", bus.pc, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] jr;
            logic [31:0] ex;
            jr = $urandom;
            ex = $urandom;
            if ($urandom_range(0, 1) == 0) jr[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) ex[1:0] = 2'b00;
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                3'($urandom_range(0, 7)),
                16'($urandom),
                26'($urandom),
                jr, ex,
                $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
